pingpong_acc_buffer: RTL and testbench
======================================

Name: pingpong_acc_buffer

Overview:
Parametrised two-bank (ping/pong) accumulator buffer between the MAC array and the store path. It saturates wide MAC results into ACC_W-bit bank entries, alternating banks on each result beat, with optional accumulate mode. On request it drains the lane-wise sum of both banks, rounded and saturated to OUT_W, over a valid/ready handshake. It extends the fixed 28/17-bit output buffer with generic widths and lane count, accumulate mode, rounding, an overflow flag and drain backpressure.

Parameters:
LANES, 16, number of MAC lanes
IN_W, 33, signed MAC result width per lane
ACC_W, 28, signed bank entry width (ACC_W < IN_W)
OUT_W, 17, signed drained output width per lane
OUT_SHIFT, 11, fractional bits dropped on drain (>= 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init  in  1  pulse: load bias into both banks
init_zero_b  in  1  with init: bank B cleared instead of loaded with bias_b
bias_a  in  ACC_W  broadcast bias for bank A
bias_b  in  ACC_W  broadcast bias for bank B
acc_mode  in  1  0 = overwrite bank entry, 1 = add into entry
in_vld  in  1  in_data valid this cycle
in_data  in  LANES*IN_W  MAC results, lane j at [j*IN_W +: IN_W]
drain_start  in  1  request one drained output vector
out_vld  out  1  out_data valid
out_rdy  in  1  consumer ready
out_data  out  LANES*OUT_W  drained vector, lane j at [j*OUT_W +: OUT_W]
busy  out  1  drain in progress (state != IDLE)
wr_bank  out  1  bank the next in_vld beat writes (0 = A, 1 = B)
ovf  out  1  sticky: any saturation since last init

Behaviour:
- Async reset: both banks all-zero, wr_bank=0, state IDLE, out_vld=0, out_data=0, busy=0, ovf=0.
- sat_acc(x): if x[IN_W-1:ACC_W-1] are all equal, result is x[ACC_W-1:0]. Otherwise the result is the max positive (0,1…1) when x is positive and the min negative (1,0…0) when x is negative, and ovf is set.
- Write (IDLE, in_vld=1, init=0): at the edge, bank[wr_bank][j] <= sat_acc(in_data[j]) when acc_mode=0. When acc_mode=1, it gets the ACC_W signed sum of the old entry and sat_acc(in_data[j]), saturated the same way (sets ovf). wr_bank toggles. Latency is 1 cycle.
- Init (any state, highest priority): bank A all lanes <= bias_a. Bank B all lanes <= init_zero_b ? 0 : bias_b. Both load on the same edge. wr_bank <= 0, ovf <= 0. Any drain is aborted: state IDLE, out_vld=0 after the edge. in_vld and drain_start in the same cycle are ignored.
- FSM states: IDLE, OUT.
  - IDLE with drain_start=1 (no init): register out_data and go to OUT. out_vld=1 in the next cycle. drain_start and in_vld in the same cycle: the drain wins and in_vld is dropped.
  - OUT: hold out_vld=1 and keep out_data stable until out_rdy=1. On the handshake edge go to IDLE, out_vld=0.
  - In OUT, in_vld and drain_start are ignored; banks are unchanged.
- Drain arithmetic per lane: s = sext(A[j]) + sext(B[j]) (ACC_W+1 bits). r = (s + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed without intermediate overflow (ACC_W+2 bits). r is saturated to signed OUT_W. ovf is NOT set by drain saturation.
- Banks are not cleared by drain. Repeated drains return the same value.
- rst asserted mid-drain: immediate return to reset values.

Test Plan:
- Init bias_a=2048, bias_b=1024, init_zero_b=0, then drain_start with out_rdy=1 -> out_vld one cycle later; every lane = (3072+1024)>>11 = 2; busy=1 for exactly 1 cycle.
- Init bias_a=bias_b=0. in_vld lane0=0x0_4000_0000 (2^30), then lane0=0x1_F000_0000 (-2^28) -> A[0]=0x7FFFFFF, B[0]=0x8000000, ovf=1, wr_bank back to 0.
- acc_mode=1, bias_a=100, init_zero_b=1, in_vld lane values 50 -> A=150, B=0. Next beat 7 -> B=7. Drain with OUT_SHIFT=11 -> every lane 0 (157+1024 < 2048).
- Both banks 0x7FFFFFF, drain -> every lane 0x0FFFF (OUT_W max). Both banks 0x8000000 -> every lane 0x10000. ovf unchanged.
- Drain with out_rdy=0 for 5 cycles while in_vld pulses -> out_vld held, out_data stable, banks unchanged. out_rdy=1 -> IDLE next cycle.
- rst pulse, or init, while in OUT -> out_vld=0, busy=0 immediately/next edge. After init, banks hold the new bias.

Source files
------------

// File: rtl/pingpong_acc_buffer.sv
// Two-bank (ping/pong) accumulator buffer. MAC results are saturated into ACC_W-bit
// bank entries, alternating banks per beat, with optional accumulate. A drain returns
// the rounded, saturated lane-wise sum of both banks over a valid/ready handshake.
module pingpong_acc_buffer #(
   parameter int unsigned LANES     = 16,
   parameter int unsigned IN_W      = 33,
   parameter int unsigned ACC_W     = 28,
   parameter int unsigned OUT_W     = 17,
   parameter int unsigned OUT_SHIFT = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   init,
   input  logic                   init_zero_b,
   input  logic [ACC_W-1:0]       bias_a,
   input  logic [ACC_W-1:0]       bias_b,
   input  logic                   acc_mode,
   input  logic                   in_vld,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic                   drain_start,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic                   busy,
   output logic                   wr_bank,
   output logic                   ovf
);

   // Drain sum is ACC_W+1 bits; one more bit keeps the rounding add from overflowing.
   localparam int unsigned SumW = ACC_W + 2;
   localparam logic [SumW-1:0]  Rnd    = SumW'(1) << (OUT_SHIFT - 1);
   localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] OutMax = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OutMin = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [0:0] {StIdle, StOut} state_e;

   state_e                 state_q, state_d;
   logic [ACC_W-1:0]       bank_a_q [LANES];
   logic [ACC_W-1:0]       bank_b_q [LANES];
   logic                   wr_bank_q;
   logic                   ovf_q;
   logic [LANES*OUT_W-1:0] out_data_q;

   logic [ACC_W-1:0]       wr_val [LANES];
   logic [LANES-1:0]       lane_sat;
   logic [LANES*OUT_W-1:0] drain_val;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [IN_W-1:0]  x;
      logic             x_ovf;
      logic [ACC_W-1:0] x_sat;
      logic [ACC_W-1:0] old_val;
      logic [ACC_W:0]   acc_sum;
      logic             acc_ovf;
      logic [ACC_W-1:0] acc_sat;
      logic [SumW-1:0]  s;
      logic [SumW-1:0]  r;
      logic             r_ovf;

      // Write path: the bits above the ACC_W sign must all match the sign to fit.
      assign x       = in_data[j*IN_W +: IN_W];
      assign x_ovf   = !((&x[IN_W-1:ACC_W-1]) || !(|x[IN_W-1:ACC_W-1]));
      assign x_sat   = x_ovf ? (x[IN_W-1] ? AccMin : AccMax) : x[ACC_W-1:0];
      assign old_val = wr_bank_q ? bank_b_q[j] : bank_a_q[j];
      assign acc_sum = {old_val[ACC_W-1], old_val} + {x_sat[ACC_W-1], x_sat};
      assign acc_ovf = acc_sum[ACC_W] != acc_sum[ACC_W-1];
      assign acc_sat = acc_ovf ? (acc_sum[ACC_W] ? AccMin : AccMax) : acc_sum[ACC_W-1:0];
      assign wr_val[j]   = acc_mode ? acc_sat : x_sat;
      assign lane_sat[j] = x_ovf | (acc_mode & acc_ovf);

      // Drain path: round-half-up then arithmetic shift, then clamp to OUT_W.
      assign s     = {{2{bank_a_q[j][ACC_W-1]}}, bank_a_q[j]}
                   + {{2{bank_b_q[j][ACC_W-1]}}, bank_b_q[j]} + Rnd;
      assign r     = $signed(s) >>> OUT_SHIFT;
      assign r_ovf = !((&r[SumW-1:OUT_W-1]) || !(|r[SumW-1:OUT_W-1]));
      assign drain_val[j*OUT_W +: OUT_W] =
         r_ovf ? (r[SumW-1] ? OutMin : OutMax) : r[OUT_W-1:0];
   end

   // Next-state logic: init aborts any drain; otherwise drain request / handshake.
   always_comb begin
      state_d = state_q;
      if (init) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (drain_start) state_d = StOut;
            StOut:   if (out_rdy)     state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // State, banks, output register and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_bank_q  <= 1'b0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         for (int j = 0; j < LANES; j++) begin
            bank_a_q[j] <= '0;
            bank_b_q[j] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (init) begin
            wr_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
               bank_a_q[j] <= bias_a;
               bank_b_q[j] <= init_zero_b ? '0 : bias_b;
            end
         end else if (state_q == StIdle && drain_start) begin
            out_data_q <= drain_val;
         end else if (state_q == StIdle && in_vld) begin
            wr_bank_q <= ~wr_bank_q;
            if (|lane_sat) ovf_q <= 1'b1;
            for (int j = 0; j < LANES; j++) begin
               if (wr_bank_q) bank_b_q[j] <= wr_val[j];
               else           bank_a_q[j] <= wr_val[j];
            end
         end
      end
   end

   assign out_vld  = (state_q == StOut);
   assign busy     = (state_q == StOut);
   assign out_data = out_data_q;
   assign wr_bank  = wr_bank_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_pingpong_acc_buffer.sv
// Randomized self-checking bench for pingpong_acc_buffer with a behavioural bank model.
module tb_pingpong_acc_buffer;
   localparam int LANES = 16;
   localparam int IN_W = 33;
   localparam int ACC_W = 28;
   localparam int OUT_W = 17;
   localparam int OUT_SHIFT = 11;
   localparam longint AccMax = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint AccMin = -(longint'(1) << (ACC_W - 1));
   localparam longint OutMax = (longint'(1) << (OUT_W - 1)) - 1;
   localparam longint OutMin = -(longint'(1) << (OUT_W - 1));

   logic clk = 1'b0, rst = 1'b1, init = 1'b0, init_zero_b = 1'b0;
   logic [ACC_W-1:0] bias_a = '0, bias_b = '0;
   logic acc_mode = 1'b0, in_vld = 1'b0, drain_start = 1'b0, out_rdy = 1'b0;
   logic [LANES*IN_W-1:0] in_data = '0;
   logic out_vld, busy, wr_bank, ovf;
   logic [LANES*OUT_W-1:0] out_data;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   longint ma [LANES];
   longint mb [LANES];
   bit mwr, movf, sat_hit;

   pingpong_acc_buffer #(
      .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .init(init), .init_zero_b(init_zero_b), .bias_a(bias_a),
      .bias_b(bias_b), .acc_mode(acc_mode), .in_vld(in_vld), .in_data(in_data),
      .drain_start(drain_start), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
      .busy(busy), .wr_bank(wr_bank), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clamp_acc(longint x);
      if (x > AccMax) begin sat_hit = 1'b1; return AccMax; end
      if (x < AccMin) begin sat_hit = 1'b1; return AccMin; end
      return x;
   endfunction

   function automatic longint sext_acc(logic [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] t;
      t = v;
      return longint'(t);
   endfunction

   function automatic logic [LANES*OUT_W-1:0] model_drain();
      logic [LANES*OUT_W-1:0] v;
      longint s, r;
      for (int j = 0; j < LANES; j++) begin
         s = ma[j] + mb[j];
         r = (s + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
         if (r > OutMax) r = OutMax;
         if (r < OutMin) r = OutMin;
         v[j*OUT_W +: OUT_W] = r[OUT_W-1:0];
      end
      return v;
   endfunction

   function automatic logic [LANES*IN_W-1:0] rand_vec();
      logic [LANES*IN_W-1:0] v;
      longint r;
      for (int j = 0; j < LANES; j++) begin
         r = longint'({$urandom, $urandom});
         r = r >>> $urandom_range(31, 45);
         v[j*IN_W +: IN_W] = r[IN_W-1:0];
      end
      return v;
   endfunction

   function automatic logic [LANES*IN_W-1:0] bcast(longint x);
      logic [LANES*IN_W-1:0] v;
      for (int j = 0; j < LANES; j++) v[j*IN_W +: IN_W] = x[IN_W-1:0];
      return v;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < LANES; j++) begin ma[j] = 0; mb[j] = 0; end
      mwr = 1'b0;
      movf = 1'b0;
   endtask

   task automatic do_init(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b, input bit zb);
      init = 1'b1; bias_a = a; bias_b = b; init_zero_b = zb;
      step();
      init = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         ma[j] = sext_acc(a);
         mb[j] = zb ? 0 : sext_acc(b);
      end
      mwr = 1'b0;
      movf = 1'b0;
   endtask

   // One write beat, applied to the model as a whole-vector operation.
   task automatic do_beat(input bit acc, input logic [LANES*IN_W-1:0] data);
      logic signed [IN_W-1:0] t;
      longint x, old;
      in_vld = 1'b1; acc_mode = acc; in_data = data;
      step();
      in_vld = 1'b0;
      sat_hit = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         t = data[j*IN_W +: IN_W];
         x = clamp_acc(longint'(t));
         old = mwr ? mb[j] : ma[j];
         if (acc) x = clamp_acc(old + x);
         if (mwr) mb[j] = x; else ma[j] = x;
      end
      if (sat_hit) movf = 1'b1;
      mwr = ~mwr;
   endtask

   // Request a drain, capture the vector, stall, then hand it off.
   task automatic drain_get(input int stall, output logic [LANES*OUT_W-1:0] data,
                            output bit ok);
      int n = 0;
      out_rdy = 1'b0; drain_start = 1'b1;
      step();
      drain_start = 1'b0;
      while (!out_vld && n < 10) begin step(); n++; end
      ok = out_vld;
      data = out_data;
      if (!ok) return;
      repeat (stall) step();
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      logic [LANES*OUT_W-1:0] d;
      bit ok;
      rst = 1'b1;
      #3;
      checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got %b want 0", wr_bank); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      step();
      rst = 1'b0;
      model_reset();
      step();
      drain_get(0, d, ok);
      checks++; if (!ok || d !== model_drain()) begin errors++; $display("FAIL reset_drain got %h want %h", d, model_drain()); end
   endtask

   task automatic test_bias_drain();
      logic [LANES*OUT_W-1:0] exp_v;
      do_init(28'd2048, 28'd1024, 1'b0);
      for (int j = 0; j < LANES; j++) exp_v[j*OUT_W +: OUT_W] = 17'd2;
      out_rdy = 1'b1; drain_start = 1'b1;
      step();
      drain_start = 1'b0;
      checks++; if (out_vld !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bias_vld got %b/%b want 1/1", out_vld, busy); end
      checks++; if (out_data !== exp_v) begin errors++; $display("FAIL bias_data got %h want %h", out_data, exp_v); end
      step();
      out_rdy = 1'b0;
      checks++; if (busy !== 1'b0 || out_vld !== 1'b0) begin errors++; $display("FAIL bias_busy_len got %b/%b want 0/0", busy, out_vld); end
   endtask

   task automatic test_sat_write();
      logic [LANES*IN_W-1:0] v;
      logic [LANES*OUT_W-1:0] d;
      bit ok;
      do_init('0, '0, 1'b0);
      v = '0; v[IN_W-1:0] = 33'h0_4000_0000;
      do_beat(1'b0, v);
      checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL sat_wr_bank1 got %b want 1", wr_bank); end
      v[IN_W-1:0] = 33'h1_F000_0000;
      do_beat(1'b0, v);
      checks++; if (ovf !== 1'b1 || ovf !== movf) begin errors++; $display("FAIL sat_ovf got %b want 1", ovf); end
      checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL sat_wr_bank0 got %b want 0", wr_bank); end
      checks++; if (ma[0] != AccMax || mb[0] != AccMin) begin errors++; $display("FAIL sat_model got %0d/%0d want %0d/%0d", ma[0], mb[0], AccMax, AccMin); end
      drain_get(0, d, ok);
      checks++; if (!ok || d !== model_drain()) begin errors++; $display("FAIL sat_drain got %h want %h", d, model_drain()); end
   endtask

   task automatic test_acc_mode();
      logic [LANES*OUT_W-1:0] d, d2;
      bit ok;
      do_init(28'd100, 28'h123, 1'b1);
      do_beat(1'b1, bcast(50));
      do_beat(1'b1, bcast(7));
      checks++; if (ma[0] != 150 || mb[0] != 7) begin errors++; $display("FAIL acc_model got %0d/%0d want 150/7", ma[0], mb[0]); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL acc_ovf got %b want 0", ovf); end
      drain_get(0, d, ok);
      checks++; if (!ok || d !== '0) begin errors++; $display("FAIL acc_drain got %h want 0", d); end
      do_beat(1'b1, bcast(4000));
      drain_get(1, d, ok);
      drain_get(0, d2, ok);
      checks++; if (d !== model_drain() || d2 !== d) begin errors++; $display("FAIL acc_repeat got %h/%h want %h", d, d2, model_drain()); end
   endtask

   task automatic test_drain_sat();
      logic [LANES*OUT_W-1:0] d, ev;
      bit ok;
      do_init(28'h7FF_FFFF, 28'h7FF_FFFF, 1'b0);
      for (int j = 0; j < LANES; j++) ev[j*OUT_W +: OUT_W] = 17'h0FFFF;
      drain_get(0, d, ok);
      checks++; if (!ok || d !== ev) begin errors++; $display("FAIL drain_sat_max got %h want %h", d, ev); end
      do_init(28'h800_0000, 28'h800_0000, 1'b0);
      for (int j = 0; j < LANES; j++) ev[j*OUT_W +: OUT_W] = 17'h10000;
      drain_get(0, d, ok);
      checks++; if (!ok || d !== ev) begin errors++; $display("FAIL drain_sat_min got %h want %h", d, ev); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL drain_sat_ovf got %b want 0", ovf); end
   endtask

   task automatic test_backpressure();
      logic [LANES*OUT_W-1:0] first, d;
      bit ok;
      do_init(28'd500000, 28'hFFF_0000, 1'b0);
      do_beat(1'b0, rand_vec());
      out_rdy = 1'b0; drain_start = 1'b1;
      step();
      drain_start = 1'b0;
      first = out_data;
      checks++; if (first !== model_drain()) begin errors++; $display("FAIL bp_first got %h want %h", first, model_drain()); end
      for (int i = 0; i < 5; i++) begin
         in_vld = 1'b1; in_data = rand_vec(); acc_mode = i[0];
         step();
         checks++; if (out_vld !== 1'b1 || out_data !== first || wr_bank !== mwr) begin errors++; $display("FAIL bp_hold cycle %0d got vld %b wr %b", i, out_vld, wr_bank); end
      end
      in_vld = 1'b0; out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got %b/%b want 0/0", out_vld, busy); end
      drain_get(0, d, ok);
      checks++; if (!ok || d !== model_drain()) begin errors++; $display("FAIL bp_banks got %h want %h", d, model_drain()); end
   endtask

   task automatic test_abort();
      logic [LANES*OUT_W-1:0] d;
      bit ok;
      do_init(28'd9000, 28'd3000, 1'b0);
      drain_start = 1'b1;
      step();
      drain_start = 1'b0;
      rst = 1'b1;
      #2;
      checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL abort_rst got %b/%b/%h want 0", out_vld, busy, out_data); end
      step();
      rst = 1'b0;
      model_reset();
      do_beat(1'b0, rand_vec());
      drain_start = 1'b1;
      step();
      // Init with drain_start and in_vld: both must be ignored.
      init = 1'b1; bias_a = 28'd777; bias_b = 28'd888; init_zero_b = 1'b0;
      in_vld = 1'b1; in_data = rand_vec();
      step();
      init = 1'b0; in_vld = 1'b0; drain_start = 1'b0;
      for (int j = 0; j < LANES; j++) begin ma[j] = 777; mb[j] = 888; end
      mwr = 1'b0; movf = 1'b0;
      checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || wr_bank !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_init got %b/%b/%b/%b want 0", out_vld, busy, wr_bank, ovf); end
      drain_get(0, d, ok);
      checks++; if (!ok || d !== model_drain()) begin errors++; $display("FAIL abort_banks got %h want %h", d, model_drain()); end
   endtask

   task automatic test_random();
      logic [LANES*OUT_W-1:0] d;
      bit ok;
      int op;
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 9);
         if (op == 0) begin
            do_init(ACC_W'($urandom), ACC_W'($urandom), 1'($urandom));
         end else if (op <= 2) begin
            drain_get($urandom_range(0, 3), d, ok);
            checks++; if (!ok || d !== model_drain()) begin errors++; $display("FAIL rand_drain iter %0d got %h want %h", i, d, model_drain()); end
         end else begin
            do_beat(1'($urandom), rand_vec());
         end
         checks++; if (wr_bank !== mwr || ovf !== movf) begin errors++; $display("FAIL rand_flags iter %0d got %b/%b want %b/%b", i, wr_bank, ovf, mwr, movf); end
      end
   endtask

   initial begin
      test_reset();
      test_bias_drain();
      test_sat_write();
      test_acc_mode();
      test_drain_sat();
      test_backpressure();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
